// File: rtl/pdts_tstamp_pkg.sv
// pdts_tstamp_pkg: state encodings and timing command codes for the timestamp tracker
package pdts_tstamp_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_TS = 2'd1,
    S_RUN     = 2'd2,
    S_ERR     = 2'd3
  } state_t;
  localparam logic [3:0] CMD_TSYNC       = 4'd0;
  localparam logic [3:0] CMD_ECHO        = 4'd1;
  localparam logic [3:0] CMD_SPILL_START = 4'd2;
  localparam logic [3:0] CMD_SPILL_STOP  = 4'd3;
  localparam logic [3:0] CMD_RUN_START   = 4'd4;
  localparam logic [3:0] CMD_RUN_STOP    = 4'd5;
  localparam logic [3:0] CMD_CALIB       = 4'd6;
  localparam logic [3:0] CMD_TRIG_BASE   = 4'd8;
endpackage

// File: rtl/pdts_grp_ctr.sv
// pdts_grp_ctr: one partition group's run flag and wrapping event counter
module pdts_grp_ctr #(
  parameter int EVT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             trig,
  output logic             running,
  output logic [EVT_W-1:0] evtctr
);
  // leaving to idle drops the run flag but keeps the count; start re-clears even if already running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      running <= 1'b0;
      evtctr  <= '0;
    end else if (clr) running <= 1'b0;
    else if (en) begin
      if (start) begin
        running <= 1'b1;
        evtctr  <= '0;
      end else if (stop) running <= 1'b0;
      else if (trig && running) evtctr <= evtctr + EVT_W'(1);
    end
endmodule

// File: rtl/pdts_tstamp_tracker.sv
// pdts_tstamp_tracker: local timestamp tracking with TimeSync checking and per-group run/event counting
module pdts_tstamp_tracker
  import pdts_tstamp_pkg::*;
#(
  parameter int TS_W  = 64,
  parameter int N_GRP = 4,
  parameter int EVT_W = 32,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic [3:0]             sync,
  input  logic                   sync_v,
  input  logic [TS_W-1:0]        ts_load,
  input  logic                   ts_load_v,
  input  logic [N_GRP-1:0]       grp_en,
  output logic [TS_W-1:0]        tstamp,
  output logic                   tstamp_v,
  output logic [N_GRP-1:0]       running,
  output logic [N_GRP*EVT_W-1:0] evtctr,
  output logic [ERR_W-1:0]       err_cnt,
  output logic [1:0]             state
);
  state_t st, st_nx;
  logic [TS_W-1:0] ts_inc, ts_nx;
  logic tracking, ld_mis, act, err_up;
  assign ts_inc   = tstamp + TS_W'(1);
  assign tracking = rdy && (st == S_RUN || st == S_ERR);
  assign ld_mis   = ts_load_v && ts_load != ts_inc;
  assign act      = tracking && sync_v;
  assign state    = st;
  // state, timestamp, validity and error count registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= S_IDLE;
      tstamp   <= '0;
      tstamp_v <= 1'b0;
      err_cnt  <= '0;
    end else begin
      st       <= st_nx;
      tstamp   <= ts_nx;
      tstamp_v <= st_nx == S_RUN;
      if (err_up) err_cnt <= err_cnt + ERR_W'(1);
    end
  // next state: losing rdy wins over everything, loads decide between RUN and ERR
  always_comb
    st_nx = !rdy             ? S_IDLE :
            st == S_IDLE     ? S_WAIT_TS :
            st == S_WAIT_TS  ? (ts_load_v ? S_RUN : S_WAIT_TS) :
            ld_mis           ? S_ERR :
            ts_load_v        ? S_RUN : st;
  // next timestamp and error-count enable
  always_comb begin
    ts_nx  = !rdy            ? '0 :
             st == S_IDLE    ? tstamp :
             st == S_WAIT_TS ? (ts_load_v ? ts_load : tstamp) :
             ld_mis          ? ts_load : ts_inc;
    err_up = tracking && ld_mis && err_cnt != '1;
  end
  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    pdts_grp_ctr #(.EVT_W(EVT_W)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!rdy),
      .en      (grp_en[g]),
      .start   (act && sync == CMD_RUN_START),
      .stop    (act && sync == CMD_RUN_STOP),
      .trig    (act && sync >= CMD_TRIG_BASE),
      .running (running[g]),
      .evtctr  (evtctr[g*EVT_W +: EVT_W])
    );
  end
endmodule

// File: tb/tb_pdts_tstamp_tracker.sv
// tb_pdts_tstamp_tracker: scoreboard bench with a behavioural model for the timestamp tracker
module tb_pdts_tstamp_tracker;
  localparam int TS_W  = 16;
  localparam int N_GRP = 4;
  localparam int EVT_W = 4;
  localparam int ERR_W = 8;
  logic clk = 0, rst_n = 0, rdy = 0, sync_v = 0, ts_load_v = 0;
  logic [3:0] sync = '0;
  logic [TS_W-1:0] ts_load = '0;
  logic [N_GRP-1:0] grp_en = '0;
  logic [TS_W-1:0] tstamp;
  logic tstamp_v;
  logic [N_GRP-1:0] running;
  logic [N_GRP*EVT_W-1:0] evtctr;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0] state;
  typedef struct packed {
    logic [1:0] st;
    logic [TS_W-1:0] ts;
    logic tv;
    logic [N_GRP-1:0] run;
    logic [N_GRP*EVT_W-1:0] evt;
    logic [ERR_W-1:0] err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int m_st, m_ts, m_err;
  bit [N_GRP-1:0] m_run;
  int m_evt[N_GRP];
  bit [N_GRP-1:0] en;
  bit r, sv, tv;
  int code, tl;

  pdts_tstamp_tracker #(.TS_W(TS_W), .N_GRP(N_GRP), .EVT_W(EVT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .sync(sync), .sync_v(sync_v),
    .ts_load(ts_load), .ts_load_v(ts_load_v), .grp_en(grp_en),
    .tstamp(tstamp), .tstamp_v(tstamp_v), .running(running),
    .evtctr(evtctr), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_st = 0; m_ts = 0; m_err = 0; m_run = '0;
    for (int g = 0; g < N_GRP; g++) m_evt[g] = 0;
  endfunction

  // states: 0 idle, 1 waiting for timestamp, 2 run, 3 error
  function automatic void step(bit rr, bit s, int c, bit t, int l, bit [N_GRP-1:0] ge);
    int nx;
    if (!rr) begin
      m_st = 0; m_ts = 0; m_run = '0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    if (m_st == 1) begin
      if (t) begin m_st = 2; m_ts = l; end
      return;
    end
    if (s)
      for (int g = 0; g < N_GRP; g++)
        if (ge[g]) begin
          if (c == 4) begin m_run[g] = 1; m_evt[g] = 0; end
          else if (c == 5) m_run[g] = 0;
          else if (c >= 8 && m_run[g]) m_evt[g] = (m_evt[g] + 1) % (1 << EVT_W);
        end
    nx = (m_ts + 1) % (1 << TS_W);
    if (t && l != nx) begin
      m_ts = l; m_st = 3;
      if (m_err < (1 << ERR_W) - 1) m_err++;
    end else begin
      m_ts = nx;
      if (t) m_st = 2;
    end
  endfunction

  function automatic exp_t snap();
    exp_t x;
    x.st = 2'(m_st);
    x.ts = TS_W'(m_ts);
    x.tv = (m_st == 2);
    x.run = m_run;
    x.err = ERR_W'(m_err);
    for (int g = 0; g < N_GRP; g++) x.evt[g*EVT_W +: EVT_W] = EVT_W'(m_evt[g]);
    return x;
  endfunction

  task automatic cyc(bit rr, bit s, int c, bit t, int l);
    @(negedge clk);
    rdy = rr; sync_v = s; sync = 4'(c); ts_load_v = t; ts_load = TS_W'(l); grp_en = en;
    step(rr, s, c, t, l % (1 << TS_W), en);
    q.push_back(snap());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", state, e.st);
      chk("tstamp", tstamp, e.ts);
      chk("tstamp_v", tstamp_v, e.tv);
      chk("running", running, e.run);
      chk("evtctr", evtctr, e.evt);
      chk("err_cnt", err_cnt, e.err);
    end
  end

  initial begin
    model_reset();
    en = '0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_tstamp", tstamp, 0);
    chk("rst_tstamp_v", tstamp_v, 0);
    chk("rst_running", running, 0);
    chk("rst_evtctr", evtctr, 0);
    chk("rst_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 'h100);
    idle(2);
    settle();
    chk("ts_0x102", tstamp, 'h102);
    cyc(1, 0, 0, 1, m_ts + 1);
    cyc(1, 0, 0, 1, m_ts + 6);
    settle();
    chk("mis_state", state, 3);
    chk("mis_err", err_cnt, 1);
    cyc(1, 0, 0, 1, m_ts + 1);
    settle();
    chk("rematch_state", state, 2);
    en = 4'b0101;
    cyc(1, 1, 4, 0, 0);
    cyc(1, 1, 8, 0, 0);
    cyc(1, 1, 9, 0, 0);
    cyc(1, 1, 15, 0, 0);
    cyc(1, 1, 5, 0, 0);
    cyc(1, 1, 8, 0, 0);
    settle();
    chk("grp_counts", evtctr, 16'h0303);
    en = 4'b1111;
    cyc(1, 1, 4, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 8 + (i % 8), 0, 0);
    settle();
    chk("evt_wrap", evtctr, 0);
    cyc(1, 1, 10, 1, m_ts + 9);
    cyc(1, 1, 2, 1, 'hFFFF);
    cyc(1, 1, 12, 1, 0);
    settle();
    chk("ts_wrap_ok", state, 2);
    for (int i = 0; i < 300; i++) cyc(1, 0, 0, 1, m_ts + 3);
    settle();
    chk("err_sat", err_cnt, 255);
    cyc(1, 0, 0, 1, m_ts + 1);
    cyc(1, 1, 9, 0, 0);
    cyc(0, 1, 8, 1, 7);
    settle();
    chk("rdy_drop_state", state, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 'h1234);
    cyc(1, 1, 4, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99) != 0;
      sv = $urandom_range(2) == 0;
      code = $urandom_range(15);
      tv = $urandom_range(4) == 0;
      tl = ($urandom_range(3) != 0) ? m_ts + 1 : $urandom_range(65535);
      if ($urandom_range(15) == 0) en = 4'($urandom);
      cyc(r, sv, code, tv, tl);
    end
    en = 4'b1111;
    idle(1);
    cyc(1, 0, 0, 1, m_ts + 1);
    cyc(1, 1, 4, 0, 0);
    cyc(1, 1, 8, 0, 0);
    settle();
    @(negedge clk);
    rdy = 0; sync_v = 0; ts_load_v = 0;
    rst_n = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_tstamp", tstamp, 0);
    chk("arst_tstamp_v", tstamp_v, 0);
    chk("arst_running", running, 0);
    chk("arst_evtctr", evtctr, 0);
    chk("arst_err", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 'h55);
    idle(3);
    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
